// File: rtl/chacha_block_serializer.sv
// ChaCha20 state-matrix to little-endian byte stream serializer.
// Loads NO_WORDS words at once and emits them byte by byte over valid/ready.
module chacha_block_serializer #(
    parameter  int DATA_SIZE    = 8,
    parameter  int NUM_MATRICES = 1,
    localparam int NO_WORDS     = 16 * NUM_MATRICES,
    localparam int NO_REG       = 64 * NUM_MATRICES,
    localparam int IW           = $clog2(NO_REG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_en,
    output logic                 load_ready,
    input  logic [31:0]          block_in [0:NO_WORDS-1],
    input  logic                 abort,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_SIZE-1:0] out_data,
    output logic                 out_last,
    output logic                 done,
    output logic [IW-1:0]        byte_idx
);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;

    localparam logic [IW-1:0] LAST = IW'(NO_REG - 1);

    state_e          state_q, state_d;
    logic [IW-1:0]   byte_idx_q, byte_idx_d;
    logic            load_d;
    logic [31:0]     storage_q [0:NO_WORDS-1];
    logic [31:0]     word_sel;

    // Next-state decode; abort overrides both the handshake and a load.
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        load_d     = 1'b0;
        if (abort) begin
            state_d    = IDLE;
            byte_idx_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (load_en) begin
                        state_d    = SEND;
                        byte_idx_d = '0;
                        load_d     = 1'b1;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (byte_idx_q == LAST) begin
                            state_d    = DONE;
                            byte_idx_d = '0;
                        end else begin
                            byte_idx_d = byte_idx_q + 1'b1;
                        end
                    end
                end
                DONE: state_d = IDLE;
                default: begin
                    state_d    = IDLE;
                    byte_idx_d = '0;
                end
            endcase
        end
    end

    // State and byte counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            byte_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
        end
    end

    // Shadow copy of the matrix words, captured only on an accepted load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NO_WORDS; i++) begin
                storage_q[i] <= '0;
            end
        end else if (load_d) begin
            for (int i = 0; i < NO_WORDS; i++) begin
                storage_q[i] <= block_in[i];
            end
        end
    end

    assign word_sel = storage_q[byte_idx_q[IW-1:2]];

    // Outputs decode registered state only; byte 0 of a word is its LSB.
    always_comb begin
        load_ready = (state_q == IDLE);
        out_valid  = (state_q == SEND);
        done       = (state_q == DONE);
        out_last   = (state_q == SEND) && (byte_idx_q == LAST);
        byte_idx   = byte_idx_q;
        out_data   = '0;
        if (state_q == SEND) begin
            out_data = word_sel[{byte_idx_q[1:0], 3'b000} +: DATA_SIZE];
        end
    end

endmodule
